uart_regfile_cmd_ctrl: RTL and testbench

//  Upstream command controller for the 8x16 register file. Consumes parallel bytes from the UART RX

---
 rtl/uart_regfile_cmd_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_regfile_cmd_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_regfile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_regfile_cmd_ctrl
//  Brief    : UART byte-frame decoder driving an 8x16 register file; returns
//             read data LSB-first to the TX serializer. Optional inter-byte
//             timeout enabled by defining CMD_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_regfile_cmd_ctrl #(
    parameter int         ADDR_WIDTH     = 3,
    parameter int         MEM_WIDTH      = 16,
    parameter logic [7:0] CMD_WR         = 8'hAA,
    parameter logic [7:0] CMD_RD         = 8'hBB,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [MEM_WIDTH-1:0]  RdData,
    input  logic                  RdData_VLD,
    input  logic                  TX_BUSY,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [MEM_WIDTH-1:0]  WrData,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CMD_ERR,
    output logic                  CTRL_BUSY
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_ADDR = 4'd1,
        S_WR_LSB  = 4'd2,
        S_WR_MSB  = 4'd3,
        S_WR_EXEC = 4'd4,
        S_RD_ADDR = 4'd5,
        S_RD_EXEC = 4'd6,
        S_RD_WAIT = 4'd7,
        S_TX_LSB  = 4'd8,
        S_TX_MSB  = 4'd9
    } state_t;

    // Sub-phases of each TX byte: send, skip one cycle for busy to rise, wait idle
    localparam logic [1:0] c_ph_send = 2'd0;
    localparam logic [1:0] c_ph_skip = 2'd1;
    localparam logic [1:0] c_ph_wait = 2'd2;

    state_t                r_state_q,   w_state_d;
    logic [1:0]            r_tx_ph_q,   w_tx_ph_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,    w_addr_d;
    logic [7:0]            r_lsb_q,     w_lsb_d;
    logic [MEM_WIDTH-1:0]  r_wdata_q,   w_wdata_d;
    logic [MEM_WIDTH-1:0]  r_rdata_q,   w_rdata_d;
    logic [7:0]            r_tx_data_q, w_tx_data_d;
    logic                  r_tx_vld_q,  w_tx_vld_d;
    logic                  r_err_q,     w_err_d;
    logic                  w_byte_taken;
    logic                  w_addr_bad;

    assign w_addr_bad = (RX_P_DATA >> ADDR_WIDTH) != 8'd0;

`ifdef CMD_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_tmo_w-1:0] r_tmo_q, w_tmo_d;
    logic               w_tmo_hit;

    assign w_tmo_hit = (r_tmo_q == c_tmo_w'(TIMEOUT_CYCLES - 1)) &&
                       (r_state_q inside {S_WR_ADDR, S_WR_LSB, S_WR_MSB, S_RD_ADDR, S_RD_WAIT});
`else
    logic w_unused_tmo;
    assign w_unused_tmo = w_byte_taken | (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_tx_ph_d    = r_tx_ph_q;
        w_addr_d     = r_addr_q;
        w_lsb_d      = r_lsb_q;
        w_wdata_d    = r_wdata_q;
        w_rdata_d    = r_rdata_q;
        w_tx_data_d  = r_tx_data_q;
        w_tx_vld_d   = 1'b0;
        w_err_d      = 1'b0;
        w_byte_taken = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR) begin
                        w_state_d    = S_WR_ADDR;
                        w_byte_taken = 1'b1;
                    end else if (RX_P_DATA == CMD_RD) begin
                        w_state_d    = S_RD_ADDR;
                        w_byte_taken = 1'b1;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            S_WR_ADDR, S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (w_addr_bad) begin
                        w_err_d   = 1'b1;
                        w_state_d = S_IDLE;
                    end else begin
                        w_addr_d     = RX_P_DATA[ADDR_WIDTH-1:0];
                        w_byte_taken = 1'b1;
                        w_state_d    = (r_state_q == S_WR_ADDR) ? S_WR_LSB : S_RD_EXEC;
                    end
                end
            end
            S_WR_LSB: begin
                if (RX_D_VLD) begin
                    w_lsb_d      = RX_P_DATA;
                    w_byte_taken = 1'b1;
                    w_state_d    = S_WR_MSB;
                end
            end
            S_WR_MSB: begin
                if (RX_D_VLD) begin
                    w_wdata_d    = {RX_P_DATA, r_lsb_q};
                    w_byte_taken = 1'b1;
                    w_state_d    = S_WR_EXEC;
                end
            end
            S_WR_EXEC: begin
                w_err_d   = RX_D_VLD;
                w_state_d = S_IDLE;
            end
            S_RD_EXEC: begin
                w_err_d   = RX_D_VLD;
                w_state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_err_d = RX_D_VLD;
                if (RdData_VLD) begin
                    w_rdata_d = RdData;
                    w_tx_ph_d = c_ph_send;
                    w_state_d = S_TX_LSB;
                end
            end
            S_TX_LSB, S_TX_MSB: begin
                w_err_d = RX_D_VLD;
                case (r_tx_ph_q)
                    c_ph_send: begin
                        if (!TX_BUSY) begin
                            w_tx_vld_d  = 1'b1;
                            w_tx_data_d = (r_state_q == S_TX_LSB) ? r_rdata_q[7:0]
                                                                  : r_rdata_q[MEM_WIDTH-1:8];
                            w_tx_ph_d   = c_ph_skip;
                        end
                    end
                    c_ph_skip: w_tx_ph_d = c_ph_wait;
                    default: begin
                        if (!TX_BUSY) begin
                            w_tx_ph_d = c_ph_send;
                            w_state_d = (r_state_q == S_TX_LSB) ? S_TX_MSB : S_IDLE;
                        end
                    end
                endcase
            end
            default: w_state_d = S_IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Abort only when this cycle made no progress on the frame
        if (w_tmo_hit && (w_state_d == r_state_q) && !w_byte_taken) begin
            w_state_d = S_IDLE;
            w_err_d   = 1'b1;
        end
        w_tmo_d = ((w_state_d != r_state_q) || w_byte_taken) ? '0 : r_tmo_q + 1'b1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q   <= S_IDLE;
            r_tx_ph_q   <= c_ph_send;
            r_addr_q    <= '0;
            r_lsb_q     <= '0;
            r_wdata_q   <= '0;
            r_rdata_q   <= '0;
            r_tx_data_q <= '0;
            r_tx_vld_q  <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_tx_ph_q   <= w_tx_ph_d;
            r_addr_q    <= w_addr_d;
            r_lsb_q     <= w_lsb_d;
            r_wdata_q   <= w_wdata_d;
            r_rdata_q   <= w_rdata_d;
            r_tx_data_q <= w_tx_data_d;
            r_tx_vld_q  <= w_tx_vld_d;
            r_err_q     <= w_err_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) r_tmo_q <= '0;
        else     r_tmo_q <= w_tmo_d;
    end
`endif

    assign WrEn      = (r_state_q == S_WR_EXEC);
    assign RdEn      = (r_state_q == S_RD_EXEC);
    assign address   = r_addr_q;
    assign WrData    = r_wdata_q;
    assign TX_P_DATA = r_tx_data_q;
    assign TX_D_VLD  = r_tx_vld_q;
    assign CMD_ERR   = r_err_q;
    assign CTRL_BUSY = (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_regfile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_regfile_cmd_ctrl
//  Brief    : Directed self-checking bench for uart_regfile_cmd_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_regfile_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_vld = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_vld = 1'b0;
    logic        tx_busy;
    logic        wr_en, rd_en, tx_vld, cmd_err, ctrl_busy;
    logic [2:0]  addr;
    logic [15:0] wr_data;
    logic [7:0]  tx_data;

    logic [15:0] model_rdata = 16'h0000;
    logic        hold_busy = 1'b0;
    int          ser_cnt = 0;

    int n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;
    logic [7:0] tx_q[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    uart_regfile_cmd_ctrl dut (
        .CLK(clk), .RST(rst), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .RdData(rd_data), .RdData_VLD(rd_vld), .TX_BUSY(tx_busy),
        .WrEn(wr_en), .RdEn(rd_en), .address(addr), .WrData(wr_data),
        .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld), .CMD_ERR(cmd_err), .CTRL_BUSY(ctrl_busy)
    );

    // Register file answers one cycle after RdEn; serializer stays busy 10 cycles per byte
    always @(posedge clk) begin
        rd_vld <= rd_en;
        if (rd_en) rd_data <= model_rdata;
        if (tx_vld) ser_cnt <= 10;
        else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
    end
    assign tx_busy = (ser_cnt != 0) || hold_busy;

    always @(negedge clk) begin
        if (wr_en) n_wr <= n_wr + 1;
        if (rd_en) n_rd <= n_rd + 1;
        if (cmd_err) n_err <= n_err + 1;
        if (wr_en && rd_en) n_both <= n_both + 1;
        if (tx_vld) tx_q.push_back(tx_data);
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
    endtask

    task automatic wait_tx(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_q.size() >= target) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({wr_en, rd_en, tx_vld, cmd_err, ctrl_busy} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {wr_en, rd_en, tx_vld, cmd_err, ctrl_busy}); end
        n_cmp++; if ({addr, wr_data, tx_data} !== 27'd0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", addr, wr_data, tx_data); end
    endtask

    task automatic test_write;
        int wr0 = n_wr, er0 = n_err, tx0 = tx_q.size();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h34); send_byte(8'h12);
        n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL write_wren: got %b expected 1", wr_en); end
        n_cmp++; if (addr !== 3'd5) begin n_bad++; $display("FAIL write_addr: got %0d expected 5", addr); end
        n_cmp++; if (wr_data !== 16'h1234) begin n_bad++; $display("FAIL write_data: got %h expected 1234", wr_data); end
        repeat (5) @(negedge clk);
        n_cmp++; if (n_wr - wr0 != 1) begin n_bad++; $display("FAIL write_pulses: got %0d expected 1", n_wr - wr0); end
        n_cmp++; if ((n_err - er0) + (tx_q.size() - tx0) != 0) begin
            n_bad++; $display("FAIL write_side: got err=%0d tx=%0d expected 0", n_err - er0, tx_q.size() - tx0); end
        n_cmp++; if (ctrl_busy !== 1'b0) begin n_bad++; $display("FAIL write_idle: got %b expected 0", ctrl_busy); end
    endtask

    task automatic test_read;
        int rd0 = n_rd, er0 = n_err, tx0 = tx_q.size();
        bit ok;
        model_rdata = 16'h8001;
        send_byte(8'hBB); send_byte(8'h02);
        n_cmp++; if (rd_en !== 1'b1 || addr !== 3'd2) begin
            n_bad++; $display("FAIL read_rden: got rden=%b addr=%0d expected 1/2", rd_en, addr); end
        wait_tx(tx0 + 2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL read_timeout: got %0d bytes expected 2", tx_q.size() - tx0); end
        else begin
            n_cmp++; if (tx_q[tx0] !== 8'h01 || tx_q[tx0+1] !== 8'h80) begin
                n_bad++; $display("FAIL read_bytes: got %h,%h expected 01,80", tx_q[tx0], tx_q[tx0+1]); end
        end
        repeat (20) @(negedge clk);
        n_cmp++; if (n_rd - rd0 != 1 || n_err != er0 || ctrl_busy !== 1'b0) begin
            n_bad++; $display("FAIL read_end: got rd=%0d err=%0d busy=%b expected 1/0/0", n_rd - rd0, n_err - er0, ctrl_busy); end
    endtask

    task automatic test_errors;
        int wr0 = n_wr, er0 = n_err;
        send_byte(8'h7E);
        n_cmp++; if (cmd_err !== 1'b1 || ctrl_busy !== 1'b0) begin
            n_bad++; $display("FAIL bad_cmd: got err=%b busy=%b expected 1/0", cmd_err, ctrl_busy); end
        send_byte(8'hAA); send_byte(8'h09);
        n_cmp++; if (cmd_err !== 1'b1 || ctrl_busy !== 1'b0) begin
            n_bad++; $display("FAIL bad_addr: got err=%b busy=%b expected 1/0", cmd_err, ctrl_busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (n_wr != wr0 || n_err - er0 != 2) begin
            n_bad++; $display("FAIL err_counts: got wr=%0d err=%0d expected 0/2", n_wr - wr0, n_err - er0); end
    endtask

    task automatic test_busy_hold;
        int er0 = n_err, tx0 = tx_q.size();
        bit ok;
        model_rdata = 16'hC3A5;
        hold_busy = 1'b1;
        send_byte(8'hBB); send_byte(8'h01);
        repeat (20) @(negedge clk);
        send_byte(8'h55);
        repeat (29) @(negedge clk);
        n_cmp++; if (tx_q.size() != tx0) begin n_bad++; $display("FAIL hold_notx: got %0d bytes expected 0", tx_q.size() - tx0); end
        n_cmp++; if (n_err - er0 != 1) begin n_bad++; $display("FAIL hold_rxerr: got %0d expected 1", n_err - er0); end
        hold_busy = 1'b0;
        wait_tx(tx0 + 2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL hold_timeout: got %0d bytes expected 2", tx_q.size() - tx0); end
        else begin
            n_cmp++; if (tx_q[tx0] !== 8'hA5 || tx_q[tx0+1] !== 8'hC3) begin
                n_bad++; $display("FAIL hold_bytes: got %h,%h expected A5,C3", tx_q[tx0], tx_q[tx0+1]); end
        end
        repeat (20) @(negedge clk);
        n_cmp++; if (ctrl_busy !== 1'b0) begin n_bad++; $display("FAIL hold_idle: got %b expected 0", ctrl_busy); end
    endtask

    task automatic test_reset_mid;
        int wr0 = n_wr;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'hFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ctrl_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: got %b expected 0", ctrl_busy); end
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        n_cmp++; if (wr_en !== 1'b1 || addr !== 3'd3 || wr_data !== 16'h2211) begin
            n_bad++; $display("FAIL midrst_write: got %b/%0d/%h expected 1/3/2211", wr_en, addr, wr_data); end
        repeat (3) @(negedge clk);
        n_cmp++; if (n_wr - wr0 != 1) begin n_bad++; $display("FAIL midrst_pulses: got %0d expected 1", n_wr - wr0); end
    endtask

    task automatic test_back_to_back;
        int tx0 = tx_q.size(), er0 = n_err;
        bit ok;
        model_rdata = 16'hABCD;
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'hCD); send_byte(8'hAB);
        @(negedge clk);
        send_byte(8'hBB); send_byte(8'h07);
        wait_tx(tx0 + 2, ok);
        n_cmp++; if (!ok || tx_q[tx0] !== 8'hCD || tx_q[tx0+1] !== 8'hAB || n_err != er0) begin
            n_bad++; $display("FAIL b2b: got ok=%b err=%0d expected CD,AB no err", ok, n_err - er0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_timeout;
        int wr0 = n_wr, er0 = n_err;
        send_byte(8'hAA); send_byte(8'h04);
        repeat (1100) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        n_cmp++; if (n_err - er0 != 1 || ctrl_busy !== 1'b0 || n_wr != wr0) begin
            n_bad++; $display("FAIL timeout: got err=%0d busy=%b wr=%0d expected 1/0/0", n_err - er0, ctrl_busy, n_wr - wr0); end
`else
        n_cmp++; if (n_err != er0 || ctrl_busy !== 1'b1 || n_wr != wr0) begin
            n_bad++; $display("FAIL no_timeout: got err=%0d busy=%b wr=%0d expected 0/1/0", n_err - er0, ctrl_busy, n_wr - wr0); end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_write;
        test_read;
        test_errors;
        test_busy_hold;
        test_reset_mid;
        test_back_to_back;
        test_timeout;
        n_cmp++; if (n_both != 0) begin n_bad++; $display("FAIL wr_rd_overlap: got %0d expected 0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
